// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: mode encoding, Nk/Nr lookup, Rcon seed,
// the xtime reduction polynomial and the engine state encoding.
package aes_pkg;

    localparam logic [1:0] MODE_128 = 2'd0;
    localparam logic [1:0] MODE_192 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;
    localparam logic [1:0] MODE_ILL = 2'd3;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } kse_state_e;

    function automatic logic [3:0] nkOf(input logic [1:0] m);
        case (m)
            MODE_128: return NK_128;
            MODE_192: return NK_192;
            MODE_256: return NK_256;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nrOf(input logic [1:0] m);
        case (m)
            MODE_128: return NR_128;
            MODE_192: return NR_192;
            MODE_256: return NR_256;
            default:  return 4'd0;
        endcase
    endfunction

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/key_schedule_engine.sv
// AES key expansion, one 32-bit word per cycle, with a round-key read port.
// Define KSE_AES256_EN to enable AES-256 (mode 2); otherwise mode 2 is rejected.
module key_schedule_engine
    import aes_pkg::*;
#(
    parameter int RK_DEPTH = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [255:0]   key,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [3:0]     nr,
    input  logic [3:0]     rk_idx,
    output logic [127:0]   rk
);

`ifdef KSE_AES256_EN
    localparam int NWORDS = RK_DEPTH * 4;
`else
    localparam int NWORDS = (RK_DEPTH * 4 < 52) ? RK_DEPTH * 4 : 52;
`endif

    kse_state_e  state_q, state_d;
    logic [31:0] words_q [NWORDS];
    logic [5:0]  wordIdx_q;
    logic [2:0]  phase_q;
    logic [3:0]  nk_q;
    logic [3:0]  nr_q;
    logic [7:0]  rcon_q;
    logic        err_q;

    logic        legalMode, acceptStart, rejectStart;
    logic [3:0]  nkStart;
    logic [5:0]  lastIdx, rkBase;
    logic [31:0] prevWord, backWord, subIn, subOut, temp, newWord;

    always_comb begin
        legalMode = (mode == MODE_128) || (mode == MODE_192);
`ifdef KSE_AES256_EN
        if (mode == MODE_256) legalMode = 1'b1;
`endif
    end

    assign acceptStart = (state_q == ST_IDLE) && start && legalMode;
    assign rejectStart = (state_q == ST_IDLE) && start && !legalMode;
    assign nkStart     = nkOf(mode);
    assign lastIdx     = {nr_q + 4'd1, 2'b00} - 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acceptStart) state_d = ST_GEN;
            ST_GEN:  if (wordIdx_q == lastIdx) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign prevWord = words_q[wordIdx_q - 6'd1];
    assign backWord = words_q[wordIdx_q - {2'b00, nk_q}];
    assign subIn    = (phase_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

    for (genvar b = 0; b < 4; b++) begin : gen_subword
        aes_sbox u_sbox (
            .data_i (subIn[8*b +: 8]),
            .data_o (subOut[8*b +: 8])
        );
    end

    // The extra SubWord at phase 4 only exists for 8-word keys.
    always_comb begin
        temp = prevWord;
        if (phase_q == 3'd0) begin
            temp = subOut ^ {rcon_q, 24'h0};
        end
`ifdef KSE_AES256_EN
        else if (nk_q == NK_256 && phase_q == 3'd4) begin
            temp = subOut;
        end
`endif
    end

    assign newWord = backWord ^ temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NWORDS; k++) words_q[k] <= '0;
            wordIdx_q <= '0;
            phase_q   <= '0;
            nk_q      <= '0;
            nr_q      <= '0;
            rcon_q    <= RCON_INIT;
            err_q     <= 1'b0;
        end else begin
            err_q <= rejectStart;
            if (acceptStart) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(nkStart)) words_q[k] <= key[255 - 32*k -: 32];
                end
                nk_q      <= nkStart;
                nr_q      <= nrOf(mode);
                wordIdx_q <= {2'b00, nkStart};
                phase_q   <= '0;
                rcon_q    <= RCON_INIT;
            end else if (state_q == ST_GEN) begin
                words_q[wordIdx_q] <= newWord;
                wordIdx_q <= wordIdx_q + 6'd1;
                phase_q   <= ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
        end
    end

    assign busy   = (state_q == ST_GEN);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign nr     = nr_q;
    assign rkBase = {rk_idx, 2'b00};

    // Reads are suppressed while the store is being rewritten.
    always_comb begin
        rk = '0;
        if (state_q != ST_GEN && rk_idx <= nr_q) begin
            rk = {words_q[rkBase], words_q[rkBase + 6'd1],
                  words_q[rkBase + 6'd2], words_q[rkBase + 6'd3]};
        end
    end

endmodule

// File: doc/key_schedule_engine.md
KEY_SCHEDULE_ENGINE -- requirements
Module: key_schedule_engine

Interface
REQ-001 SHALL have parameter RK_DEPTH, default 15, the number of 128-bit round-key slots (Nr+1 for AES-256).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request expansion of key and mode; sampled only in IDLE.
REQ-005 SHALL have port mode, input, 2, key size: 0 is AES-128 (Nk=4, Nr=10), 1 is AES-192 (Nk=6, Nr=12), 2 is AES-256 (Nk=8, Nr=14), 3 is illegal.
REQ-006 SHALL have port key, input, 256, cipher key, MSB-first and left-aligned; unused low bits are ignored.
REQ-007 SHALL have port busy, output, 1, high while words are being generated.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the schedule is complete.
REQ-009 SHALL have port err, output, 1, one-cycle pulse when start is rejected.
REQ-010 SHALL have port nr, output, 4, the Nr of the last accepted mode.
REQ-011 SHALL have port rk_idx, input, 4, selects the round key to read.
REQ-012 SHALL have port rk, output, 128, round key rk_idx, read combinationally from the word store (words 4*rk_idx to 4*rk_idx+3).

Function
REQ-013 SHALL implement an FSM with states IDLE, GEN and DONE.
REQ-014 In IDLE, start with a legal mode SHALL:
- load words w[0..Nk-1] from key;
- latch Nk, Nr and nr;
- set the word index i=Nk, the phase counter j=0 and the Rcon register to 0x01;
- go to GEN.
REQ-015 In IDLE, start with an illegal mode SHALL pulse err for one cycle, stay in IDLE, and leave the word store and nr unchanged.
REQ-016 In GEN, exactly one word SHALL be written per cycle: w[i] = w[i-Nk] XOR temp, where temp = w[i-1] with these exceptions:
- j==0: temp = SubWord(RotWord(w[i-1])) XOR {Rcon,24'h0};
- Nk==8 and j==4: temp = SubWord(w[i-1]).
REQ-017 j SHALL wrap from Nk-1 to 0; the modulo operator SHALL NOT be used.
REQ-018 After each j==0 word, Rcon SHALL advance by xtime: shift left 1, and XOR 0x1B on carry-out (0x80 becomes 0x1B, then 0x36).
REQ-019 When the word with i == 4*(Nr+1)-1 is written, the FSM SHALL go to DONE; GEN SHALL last 40, 46 or 52 cycles for modes 0, 1 or 2.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE; busy SHALL be high only in GEN.
REQ-021 start during GEN or DONE SHALL be ignored, with no err pulse and no queuing.
REQ-022 If rk_idx > nr, rk SHALL return zero; during GEN, rk SHALL be marked not valid (contents unspecified to the user, deterministic in RTL).
REQ-023 The schedule SHALL persist after done until the next accepted start.

Reset
REQ-024 On rst_n low, regardless of state, the block SHALL:
- go to IDLE;
- drive busy, done and err to 0 and nr to 0;
- clear the word store, i and j to 0;
- set Rcon to 0x01.
REQ-025 A reset during GEN SHALL abort the expansion with no done pulse; the first start after reset release SHALL behave normally.

Configuration
REQ-026 Macro KSE_AES256_EN:
- Defined: mode 2 is legal and the j==4 SubWord path exists.
- Undefined: mode 2 is rejected like mode 3 (err pulse), the Nk==8 path is not synthesised, and the word store shrinks to 52 words.

Structure
REQ-027 Package aes_pkg SHALL hold:
- the mode encoding constants;
- the Nk/Nr lookup constants;
- the Rcon reset value 0x01;
- the xtime polynomial 0x1B.
REQ-028 Sub-module aes_sbox (8-bit combinational S-box) SHALL be instantiated four times to form SubWord; there SHALL be no other sub-modules.

Verification
REQ-029 Mode 0, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse: done exactly 41 cycles after the start edge, rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6, nr=10.
REQ-030 Mode 1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: rk_idx=12 gives e98ba06f448c773c8ecc720401002202, nr=12, done after 47 cycles.
REQ-031 Mode 2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: rk_idx=14 gives fe4890d1e6188d0b046df344706c631e; with KSE_AES256_EN undefined, the same stimulus gives an err pulse and no busy.
REQ-032 Mode 3 start gives a one-cycle err pulse and the previous schedule unchanged; start asserted during GEN is ignored and yields exactly one done pulse.
REQ-033 rst_n asserted in GEN cycle 20 gives busy=0 with no done pulse, and rk_idx=0 reads zero; a mode 0 start after release reproduces the REQ-029 result.
